// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states, grant owner
// and the width of the access-cycle counter.
package dmem_ctrl_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      CPU_ACC,
      LD_ACC
   } dmem_state_t;

   typedef enum logic {
      GNT_CPU,
      GNT_LD
   } dmem_gnt_t;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-requester round-robin arbiter (CPU vs loader). Remembers the last grant
// so that, under contention, the other side wins next.
module dmem_rr_arb
   import dmem_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      req_cpu,
   input  logic      req_ld,
   input  logic      take,
   output dmem_gnt_t gnt
);

   dmem_gnt_t last_gnt_q;

   always_comb begin
      gnt = GNT_CPU;
      if (req_ld && (!req_cpu || last_gnt_q == GNT_CPU)) begin
         gnt = GNT_LD;
      end
   end

   // Reset to LD so the CPU wins the first contention.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt_q <= GNT_LD;
      end else if (take) begin
         last_gnt_q <= gnt;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory access controller: sequences WAIT_CYCLES+1 cycle accesses
// and stalls the pipeline. Define DMEM_LOADER_EN to add the arbitrated loader port.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memreadM,
   input  logic              memwriteM,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [DATA_W-1:0] writedataM,
   output logic [DATA_W-1:0] readdataM,
   output logic              stallM,
   input  logic              ld_valid,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ready,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAST_CNT = WAIT_CYCLES[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   dmem_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cpu_req, ld_req, gnt_ld, last_cyc, act, src_ld;

   assign cpu_req  = memreadM | memwriteM;
   assign last_cyc = (cnt_q == LAST_CNT);

`ifdef DMEM_LOADER_EN
   dmem_gnt_t gnt;
   logic      gnt_take;

   assign ld_req   = ld_valid;
   assign gnt_take = (state_q == IDLE) & (cpu_req | ld_req);
   assign gnt_ld   = (gnt == GNT_LD);

   dmem_rr_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_cpu (cpu_req),
      .req_ld  (ld_req),
      .take    (gnt_take),
      .gnt     (gnt)
   );
`else
   logic unused_ld;

   assign ld_req    = 1'b0;
   assign gnt_ld    = 1'b0;
   assign unused_ld = ^{ld_valid, ld_we, ld_addr, ld_wdata};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The grant cycle in IDLE is the first access cycle; cnt is 0 there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act     = 1'b0;
      src_ld  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu_req || ld_req) begin
               act    = 1'b1;
               src_ld = gnt_ld;
               if (!last_cyc) begin
                  state_d = gnt_ld ? LD_ACC : CPU_ACC;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CPU_ACC: begin
            // A dropped request is a pipeline flush: abandon without writing.
            act = cpu_req;
            if (!cpu_req || last_cyc) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`ifdef DMEM_LOADER_EN
         LD_ACC: begin
            act    = 1'b1;
            src_ld = 1'b1;
            if (last_cyc) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      mem_en    = act;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      readdataM = '0;
      ld_ready  = 1'b0;
      ld_rdata  = '0;
      if (act && !src_ld) begin
         mem_addr  = aluoutM;
         mem_wdata = writedataM;
         if (last_cyc) begin
            mem_we    = memwriteM;
            readdataM = mem_rdata;
         end
      end
`ifdef DMEM_LOADER_EN
      if (act && src_ld) begin
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
         if (last_cyc) begin
            mem_we   = ld_we;
            ld_ready = 1'b1;
            ld_rdata = mem_rdata;
         end
      end
`endif
      // Stall also covers cycles where the loader owns the memory.
      stallM = cpu_req & ~(act & ~src_ld & last_cyc);
      if (reset) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         readdataM = '0;
         ld_ready  = 1'b0;
         ld_rdata  = '0;
         stallM    = 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (WAIT_CYCLES 0, 2, 3) share the
// stimulus, each with its own behavioural memory.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memreadM, memwriteM, ld_valid, ld_we;
   logic [31:0] aluoutM, writedataM, ld_addr, ld_wdata;

   logic [31:0] readdata0, ldrdata0, addr0, wdata0, rdata0;
   logic [31:0] readdata2, ldrdata2, addr2, wdata2, rdata2;
   logic [31:0] readdata3, ldrdata3, addr3, wdata3, rdata3;
   logic        stall0, ldready0, en0, we0;
   logic        stall2, ldready2, en2, we2;
   logic        stall3, ldready3, en3, we3;

   logic [31:0] mem0 [64];
   logic [31:0] mem2 [64];
   logic [31:0] mem3 [64];
   bit          inited = 1'b0;
   int          we_cnt2 = 0;
   int          we_cnt3 = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) dut0 (
      .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
      .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdata0), .stallM(stall0),
      .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ready(ldready0), .ld_rdata(ldrdata0), .mem_en(en0), .mem_we(we0),
      .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0)
   );

   dmem_ctrl #(.WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut2 (
      .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
      .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdata2), .stallM(stall2),
      .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ready(ldready2), .ld_rdata(ldrdata2), .mem_en(en2), .mem_we(we2),
      .mem_addr(addr2), .mem_wdata(wdata2), .mem_rdata(rdata2)
   );

   dmem_ctrl #(.WAIT_CYCLES(3), .ADDR_W(32), .DATA_W(32)) dut3 (
      .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
      .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdata3), .stallM(stall3),
      .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ready(ldready3), .ld_rdata(ldrdata3), .mem_en(en3), .mem_we(we3),
      .mem_addr(addr3), .mem_wdata(wdata3), .mem_rdata(rdata3)
   );

   // Word i of every memory starts at 0x1000_0000 + i and survives resets.
   always @(posedge clk) begin
      if (!inited) begin
         for (int i = 0; i < 64; i++) begin
            mem0[i] <= 32'h1000_0000 + 32'(i);
            mem2[i] <= 32'h1000_0000 + 32'(i);
            mem3[i] <= 32'h1000_0000 + 32'(i);
         end
         inited <= 1'b1;
      end else begin
         if (en0 && we0) mem0[addr0[7:2]] <= wdata0;
         if (en2 && we2) begin
            mem2[addr2[7:2]] <= wdata2;
            we_cnt2 <= we_cnt2 + 1;
         end
         if (en3 && we3) begin
            mem3[addr3[7:2]] <= wdata3;
            we_cnt3 <= we_cnt3 + 1;
         end
      end
   end

   assign rdata0 = mem0[addr0[7:2]];
   assign rdata2 = mem2[addr2[7:2]];
   assign rdata3 = mem3[addr3[7:2]];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      memreadM   = 1'b0;
      memwriteM  = 1'b0;
      aluoutM    = '0;
      writedataM = '0;
      ld_valid   = 1'b0;
      ld_we      = 1'b0;
      ld_addr    = '0;
      ld_wdata   = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      memwriteM  = 1'b1;
      aluoutM    = 32'h40;
      writedataM = 32'h1234_5678;
      ld_valid   = 1'b1;
      ld_we      = 1'b1;
      ld_addr    = 32'h44;
      @(negedge clk);
      n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", stall2); end
      n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL rst_en got %b exp 0", en2); end
      n_cmp++; if (we2 !== 1'b0) begin n_err++; $display("FAIL rst_we got %b exp 0", we2); end
      n_cmp++; if (addr2 !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", addr2); end
      n_cmp++; if (wdata2 !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %h exp 0", wdata2); end
      n_cmp++; if (ldready2 !== 1'b0) begin n_err++; $display("FAIL rst_ldready got %b exp 0", ldready2); end
      n_cmp++; if (en0 !== 1'b0) begin n_err++; $display("FAIL rst_en0 got %b exp 0", en0); end
      apply_reset();
      @(negedge clk);
      n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL post_rst_stall got %b exp 0", stall2); end
      n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL post_rst_en got %b exp 0", en2); end
   endtask

   task automatic test_wait0();
      apply_reset();
      memwriteM  = 1'b1;
      aluoutM    = 32'h10;
      writedataM = 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL w0_st_stall got %b exp 0", stall0); end
      n_cmp++; if (we0 !== 1'b1) begin n_err++; $display("FAIL w0_st_we got %b exp 1", we0); end
      step();
      memwriteM = 1'b0;
      memreadM  = 1'b1;
      @(negedge clk);
      n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL w0_ld_stall got %b exp 0", stall0); end
      n_cmp++; if (readdata0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL w0_ld_data got %h exp deadbeef", readdata0); end
      step();
      memreadM = 1'b0;
   endtask

   task automatic test_load_wait2();
      apply_reset();
      memreadM = 1'b1;
      aluoutM  = 32'h20;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (stall2 !== (c < 2)) begin n_err++; $display("FAIL ld2_stall c%0d got %b exp %b", c, stall2, c < 2); end
         n_cmp++; if (we2 !== 1'b0) begin n_err++; $display("FAIL ld2_we c%0d got %b exp 0", c, we2); end
         n_cmp++; if (addr2 !== 32'h20) begin n_err++; $display("FAIL ld2_addr c%0d got %h exp 20", c, addr2); end
         n_cmp++; if (readdata2 !== (c == 2 ? 32'h1000_0008 : 32'h0)) begin n_err++; $display("FAIL ld2_data c%0d got %h", c, readdata2); end
         step();
      end
      memreadM = 1'b0;
      @(negedge clk);
      n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL ld2_idle_en got %b exp 0", en2); end
      n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL ld2_idle_stall got %b exp 0", stall2); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      memwriteM  = 1'b1;
      aluoutM    = 32'h24;
      writedataM = 32'hA5A5_0001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (stall2 !== (c < 2)) begin n_err++; $display("FAIL b2b_st_stall c%0d got %b exp %b", c, stall2, c < 2); end
         n_cmp++; if (we2 !== (c == 2)) begin n_err++; $display("FAIL b2b_st_we c%0d got %b exp %b", c, we2, c == 2); end
         step();
      end
      memwriteM = 1'b0;
      memreadM  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (en2 !== 1'b1) begin n_err++; $display("FAIL b2b_ld_en c%0d got %b exp 1", c, en2); end
         n_cmp++; if (stall2 !== (c < 2)) begin n_err++; $display("FAIL b2b_ld_stall c%0d got %b exp %b", c, stall2, c < 2); end
         if (c == 2) begin
            n_cmp++; if (readdata2 !== 32'hA5A5_0001) begin n_err++; $display("FAIL b2b_ld_data got %h exp a5a50001", readdata2); end
         end
         step();
      end
      memreadM = 1'b0;
   endtask

   task automatic test_reset_mid();
      int base;
      apply_reset();
      base       = we_cnt2;
      memwriteM  = 1'b1;
      aluoutM    = 32'h30;
      writedataM = 32'hBAD0_0030;
      @(negedge clk);
      n_cmp++; if (we2 !== 1'b0) begin n_err++; $display("FAIL rmid_c1_we got %b exp 0", we2); end
      step();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (we2 !== 1'b0) begin n_err++; $display("FAIL rmid_c2_we got %b exp 0", we2); end
      n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL rmid_c2_stall got %b exp 0", stall2); end
      step();
      memwriteM = 1'b0;
      step();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL rmid_after_stall got %b exp 0", stall2); end
      n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL rmid_after_en got %b exp 0", en2); end
      step();
      memreadM = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (stall2 !== (c < 2)) begin n_err++; $display("FAIL rmid_rd_stall c%0d got %b exp %b", c, stall2, c < 2); end
         if (c == 2) begin
            n_cmp++; if (readdata2 !== 32'h1000_000C) begin n_err++; $display("FAIL rmid_rd_data got %h exp 1000000c", readdata2); end
         end
         step();
      end
      memreadM = 1'b0;
      n_cmp++; if (we_cnt2 !== base) begin n_err++; $display("FAIL rmid_writes got %0d exp %0d", we_cnt2, base); end
   endtask

   task automatic test_flush();
      int base;
      apply_reset();
      base       = we_cnt3;
      memwriteM  = 1'b1;
      aluoutM    = 32'h34;
      writedataM = 32'h0000_0055;
      @(negedge clk);
      n_cmp++; if (stall3 !== 1'b1) begin n_err++; $display("FAIL fl_c1_stall got %b exp 1", stall3); end
      n_cmp++; if (we3 !== 1'b0) begin n_err++; $display("FAIL fl_c1_we got %b exp 0", we3); end
      step();
      memwriteM = 1'b0;
      @(negedge clk);
      n_cmp++; if (stall3 !== 1'b0) begin n_err++; $display("FAIL fl_c2_stall got %b exp 0", stall3); end
      n_cmp++; if (we3 !== 1'b0) begin n_err++; $display("FAIL fl_c2_we got %b exp 0", we3); end
      n_cmp++; if (en3 !== 1'b0) begin n_err++; $display("FAIL fl_c2_en got %b exp 0", en3); end
      step();
      // A fresh read right after the flush must take the full four cycles.
      memreadM = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++; if (stall3 !== (c < 3)) begin n_err++; $display("FAIL fl_rd_stall c%0d got %b exp %b", c, stall3, c < 3); end
         if (c == 3) begin
            n_cmp++; if (readdata3 !== 32'h1000_000D) begin n_err++; $display("FAIL fl_rd_data got %h exp 1000000d", readdata3); end
         end
         step();
      end
      memreadM = 1'b0;
      n_cmp++; if (we_cnt3 !== base) begin n_err++; $display("FAIL fl_writes got %0d exp %0d", we_cnt3, base); end
   endtask

`ifdef DMEM_LOADER_EN
   task automatic test_contention();
      apply_reset();
      ld_valid   = 1'b1;
      ld_we      = 1'b0;
      ld_addr    = 32'h3C;
      memwriteM  = 1'b1;
      aluoutM    = 32'h28;
      writedataM = 32'h0000_0077;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c < 3) begin
            n_cmp++; if (stall2 !== (c < 2)) begin n_err++; $display("FAIL cn_stall c%0d got %b exp %b", c, stall2, c < 2); end
            n_cmp++; if (we2 !== (c == 2)) begin n_err++; $display("FAIL cn_we c%0d got %b exp %b", c, we2, c == 2); end
            n_cmp++; if (addr2 !== 32'h28) begin n_err++; $display("FAIL cn_cpu_addr c%0d got %h exp 28", c, addr2); end
         end else begin
            n_cmp++; if (addr2 !== 32'h3C) begin n_err++; $display("FAIL cn_ld_addr c%0d got %h exp 3c", c, addr2); end
         end
         n_cmp++; if (ldready2 !== (c == 5)) begin n_err++; $display("FAIL cn_ready c%0d got %b exp %b", c, ldready2, c == 5); end
         if (c == 5) begin
            n_cmp++; if (ldrdata2 !== 32'h1000_000F) begin n_err++; $display("FAIL cn_rdata got %h exp 1000000f", ldrdata2); end
         end
         step();
         if (c == 2) memwriteM = 1'b0;
      end
      ld_valid = 1'b0;
   endtask

   task automatic test_alternate();
      apply_reset();
      memreadM = 1'b1;
      aluoutM  = 32'h20;
      ld_valid = 1'b1;
      ld_we    = 1'b0;
      ld_addr  = 32'h3C;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_cmp++; if (addr2 !== (((c / 3) % 2 == 0) ? 32'h20 : 32'h3C)) begin n_err++; $display("FAIL alt_addr c%0d got %h", c, addr2); end
         n_cmp++; if (stall2 !== (c % 6 != 2)) begin n_err++; $display("FAIL alt_stall c%0d got %b exp %b", c, stall2, c % 6 != 2); end
         n_cmp++; if (ldready2 !== (c % 6 == 5)) begin n_err++; $display("FAIL alt_ready c%0d got %b exp %b", c, ldready2, c % 6 == 5); end
         step();
      end
      idle_inputs();
   endtask
`else
   task automatic test_no_loader();
      apply_reset();
      ld_valid = 1'b1;
      ld_we    = 1'b1;
      ld_addr  = 32'h38;
      ld_wdata = 32'h0000_0099;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (en2 !== 1'b0) begin n_err++; $display("FAIL nold_en c%0d got %b exp 0", c, en2); end
         n_cmp++; if (ldready2 !== 1'b0) begin n_err++; $display("FAIL nold_ready c%0d got %b exp 0", c, ldready2); end
         n_cmp++; if (ldrdata2 !== 32'h0) begin n_err++; $display("FAIL nold_rdata c%0d got %h exp 0", c, ldrdata2); end
         step();
      end
      memreadM = 1'b1;
      aluoutM  = 32'h20;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (stall2 !== (c < 2)) begin n_err++; $display("FAIL nold_cpu_stall c%0d got %b exp %b", c, stall2, c < 2); end
         n_cmp++; if (addr2 !== 32'h20) begin n_err++; $display("FAIL nold_cpu_addr c%0d got %h exp 20", c, addr2); end
         step();
      end
      idle_inputs();
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_wait0();
      test_load_wait2();
      test_back_to_back();
      test_reset_mid();
      test_flush();
`ifdef DMEM_LOADER_EN
      test_contention();
      test_alternate();
`else
      test_no_loader();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
